free_reg_pool: RTL and testbench



---
 rtl/free_reg_pool.sv | 117 +++++++++++
 tb/tb_free_reg_pool.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/free_reg_pool.sv
// Multi-port physical register free pool with internal branch checkpoints.
// Grants up to ALLOC_W lowest-index free tags per cycle and accepts FREE_W returns per cycle.
module free_reg_pool #(
    parameter int NUM_REGS = 64,
    parameter int NUM_ARCH = 16,
    parameter int ALLOC_W  = 2,
    parameter int FREE_W   = 2,
    parameter int NUM_CKPT = 4,
    localparam int TAG_W   = $clog2(NUM_REGS),
    localparam int CK_W    = $clog2(NUM_CKPT)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ALLOC_W-1:0]        alloc_req,
    output logic                      alloc_gnt,
    output logic [ALLOC_W*TAG_W-1:0]  alloc_tag,
    output logic                      stall,
    input  logic [FREE_W-1:0]         free_valid,
    input  logic [FREE_W*TAG_W-1:0]   free_tag,
    input  logic                      ckpt_save,
    input  logic [CK_W-1:0]           ckpt_save_id,
    input  logic                      ckpt_restore,
    input  logic [CK_W-1:0]           ckpt_restore_id,
    output logic [TAG_W:0]            free_count,
    output logic                      err_double_free
);

    localparam logic [NUM_REGS-1:0] RESET_FB = {NUM_REGS{1'b1}} << NUM_ARCH;
    localparam logic [TAG_W:0]      RESET_CNT = (TAG_W+1)'(NUM_REGS - NUM_ARCH);

    logic [NUM_REGS-1:0] fb;
    logic [NUM_REGS-1:0] ck [NUM_CKPT];
    logic [NUM_REGS-1:0] avail;
    logic [NUM_REGS-1:0] granted;
    logic [NUM_REGS-1:0] freed;
    logic [NUM_REGS-1:0] fb_next;
    logic [NUM_REGS-1:0] fb_upd;
    logic [TAG_W:0]      req_cnt;
    logic [TAG_W-1:0]    ftag;
    logic                found;
    logic                dbl;

    function automatic logic [TAG_W:0] popcnt(input logic [NUM_REGS-1:0] v);
        logic [TAG_W:0] c;
        c = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++)
            c = c + {{TAG_W{1'b0}}, v[i]};
        return c;
    endfunction

    // free_count always equals popcount(fb), so it doubles as the availability figure
    always_comb begin
        req_cnt = '0;
        for (int unsigned l = 0; l < ALLOC_W; l++)
            req_cnt = req_cnt + {{TAG_W{1'b0}}, alloc_req[l]};
        alloc_gnt = (req_cnt <= free_count) && !ckpt_restore;
        stall     = (|alloc_req) && !alloc_gnt;
    end

    always_comb begin
        avail     = fb;
        granted   = '0;
        alloc_tag = '0;
        found     = 1'b0;
        for (int unsigned l = 0; l < ALLOC_W; l++) begin
            if (alloc_req[l] && alloc_gnt) begin
                found = 1'b0;
                for (int unsigned r = 0; r < NUM_REGS; r++) begin
                    if (!found && avail[r]) begin
                        found                        = 1'b1;
                        avail[r]                     = 1'b0;
                        granted[r]                   = 1'b1;
                        alloc_tag[l*TAG_W +: TAG_W]  = TAG_W'(r);
                    end
                end
            end
        end
    end

    always_comb begin
        freed = '0;
        dbl   = 1'b0;
        ftag  = '0;
        for (int unsigned j = 0; j < FREE_W; j++) begin
            if (free_valid[j]) begin
                ftag = free_tag[j*TAG_W +: TAG_W];
                if (fb[ftag] || freed[ftag])
                    dbl = 1'b1;
                freed[ftag] = 1'b1;
            end
        end
        fb_next = (fb & ~granted) | freed;
        fb_upd  = ckpt_restore ? (ck[ckpt_restore_id] | freed) : fb_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fb              <= RESET_FB;
            free_count      <= RESET_CNT;
            err_double_free <= 1'b0;
            for (int unsigned k = 0; k < NUM_CKPT; k++)
                ck[k] <= RESET_FB;
        end else begin
            fb              <= fb_upd;
            free_count      <= popcnt(fb_upd);
            err_double_free <= dbl;
            // frees reach every slot so a later restore never resurrects a committed tag
            for (int unsigned k = 0; k < NUM_CKPT; k++) begin
                if (ckpt_save && !ckpt_restore && (CK_W'(k) == ckpt_save_id))
                    ck[k] <= fb_next;
                else
                    ck[k] <= ck[k] | freed;
            end
        end
    end

endmodule

// File: tb/tb_free_reg_pool.sv
// Self-checking bench for free_reg_pool: directed scenarios plus randomized traffic
// checked against a behavioural bit-array model of the pool.
module tb_free_reg_pool;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  alloc_req;
    logic        alloc_gnt;
    logic [11:0] alloc_tag;
    logic        stall;
    logic [1:0]  free_valid;
    logic [11:0] free_tag;
    logic        ckpt_save;
    logic [1:0]  ckpt_save_id;
    logic        ckpt_restore;
    logic [1:0]  ckpt_restore_id;
    logic [6:0]  free_count;
    logic        err_double_free;

    int n_chk = 0;
    int n_pass = 0;

    // reference model state
    bit m_fb [64];
    bit m_ck [4][64];
    int m_cnt;
    bit m_err;
    bit n_fb [64];
    bit n_ck [4][64];
    int n_cnt;
    bit n_err;
    bit e_gnt;
    bit e_stall;
    int e_tag [2];

    free_reg_pool #(.NUM_REGS(64), .NUM_ARCH(16), .ALLOC_W(2), .FREE_W(2), .NUM_CKPT(4)) dut (
        .clk(clk), .rst(rst), .alloc_req(alloc_req), .alloc_gnt(alloc_gnt),
        .alloc_tag(alloc_tag), .stall(stall), .free_valid(free_valid), .free_tag(free_tag),
        .ckpt_save(ckpt_save), .ckpt_save_id(ckpt_save_id), .ckpt_restore(ckpt_restore),
        .ckpt_restore_id(ckpt_restore_id), .free_count(free_count),
        .err_double_free(err_double_free)
    );

    always #5 clk = ~clk;

    task automatic set_in(input bit r, input bit [1:0] req, input bit [1:0] fv, input int t0,
                          input int t1, input bit sv, input int sid, input bit rs, input int rid);
        bit gm [64];
        bit fr [64];
        int f, rq, nxt, tg;
        bit err;
        rst = r; alloc_req = req; free_valid = fv; free_tag = {6'(t1), 6'(t0)};
        ckpt_save = sv; ckpt_save_id = 2'(sid); ckpt_restore = rs; ckpt_restore_id = 2'(rid);
        f = 0;
        for (int i = 0; i < 64; i++) begin f += int'(m_fb[i]); gm[i] = 0; fr[i] = 0; end
        rq = int'(req[0]) + int'(req[1]);
        e_gnt = (rq <= f) && !rs;
        e_stall = (rq != 0) && !e_gnt;
        e_tag[0] = 0; e_tag[1] = 0;
        nxt = 0;
        if (e_gnt) begin
            for (int l = 0; l < 2; l++) begin
                if (req[l]) begin
                    while (!m_fb[nxt]) nxt++;
                    e_tag[l] = nxt; gm[nxt] = 1; nxt++;
                end
            end
        end
        err = 0;
        for (int l = 0; l < 2; l++) begin
            if (fv[l]) begin
                tg = (l == 0) ? t0 : t1;
                if (m_fb[tg] || fr[tg]) err = 1;
                fr[tg] = 1;
            end
        end
        n_cnt = 0;
        for (int i = 0; i < 64; i++) begin
            n_fb[i] = rs ? (m_ck[rid][i] | fr[i]) : ((m_fb[i] & !gm[i]) | fr[i]);
            n_cnt += int'(n_fb[i]);
        end
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < 64; i++)
                n_ck[k][i] = (sv && !rs && k == sid) ? n_fb[i] : (m_ck[k][i] | fr[i]);
        n_err = err;
        if (r) begin
            for (int i = 0; i < 64; i++) begin
                n_fb[i] = (i >= 16);
                for (int k = 0; k < 4; k++) n_ck[k][i] = (i >= 16);
            end
            n_cnt = 48; n_err = 0;
        end
    endtask

    task automatic drv(input bit [1:0] req, input bit [1:0] fv, input int t0, input int t1);
        set_in(0, req, fv, t0, t1, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk); #1;
        m_fb = n_fb; m_ck = n_ck; m_cnt = n_cnt; m_err = n_err;
    endtask

    task automatic test_reset();
        set_in(1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
        tick(); tick();
        n_chk++; if (free_count !== 7'd48) $display("FAIL reset_count: got %0d want 48", free_count); else n_pass++;
        n_chk++; if (err_double_free !== 1'b0) $display("FAIL reset_err: got %0b want 0", err_double_free); else n_pass++;
        drv(2'b00, 2'b00, 0, 0); #1;
        n_chk++; if (alloc_gnt !== 1'b1 || stall !== 1'b0) $display("FAIL reset_idle: gnt %0b stall %0b want 1 0", alloc_gnt, stall); else n_pass++;
    endtask

    task automatic test_basic_grant();
        drv(2'b11, 2'b00, 0, 0); #1;
        n_chk++; if (alloc_gnt !== 1'b1 || alloc_tag !== {6'd17, 6'd16}) $display("FAIL basic_2lane: gnt %0b tags %0d,%0d want 1 16,17", alloc_gnt, alloc_tag[5:0], alloc_tag[11:6]); else n_pass++;
        tick();
        drv(2'b10, 2'b00, 0, 0); #1;
        n_chk++; if (alloc_gnt !== 1'b1 || alloc_tag !== {6'd18, 6'd0}) $display("FAIL basic_lane1: gnt %0b tags %0d,%0d want 1 0,18", alloc_gnt, alloc_tag[5:0], alloc_tag[11:6]); else n_pass++;
        tick();
        n_chk++; if (free_count !== 7'd45) $display("FAIL basic_count: got %0d want 45", free_count); else n_pass++;
    endtask

    task automatic test_exhaust();
        int bad = 0;
        test_reset();
        for (int c = 0; c < 24; c++) begin
            drv(2'b11, 2'b00, 0, 0); #1;
            if (alloc_gnt !== 1'b1 || alloc_tag[5:0] !== 6'(16 + 2*c) || alloc_tag[11:6] !== 6'(17 + 2*c)) bad++;
            tick();
        end
        n_chk++; if (bad != 0) $display("FAIL exhaust_seq: %0d bad grants want 0", bad); else n_pass++;
        n_chk++; if (free_count !== 7'd0) $display("FAIL exhaust_count: got %0d want 0", free_count); else n_pass++;
        drv(2'b01, 2'b01, 40, 0); #1;
        n_chk++; if (stall !== 1'b1 || alloc_gnt !== 1'b0) $display("FAIL exhaust_stall: stall %0b gnt %0b want 1 0", stall, alloc_gnt); else n_pass++;
        tick();
        drv(2'b01, 2'b00, 0, 0); #1;
        n_chk++; if (alloc_gnt !== 1'b1 || alloc_tag[5:0] !== 6'd40) $display("FAIL exhaust_refill: gnt %0b tag %0d want 1 40", alloc_gnt, alloc_tag[5:0]); else n_pass++;
        tick();
        n_chk++; if (free_count !== 7'd0) $display("FAIL exhaust_count2: got %0d want 0", free_count); else n_pass++;
    endtask

    task automatic test_shortage();
        test_reset();
        for (int c = 0; c < 23; c++) begin drv(2'b11, 2'b00, 0, 0); tick(); end
        drv(2'b01, 2'b00, 0, 0); #1;
        n_chk++; if (alloc_tag[5:0] !== 6'd62) $display("FAIL short_62: got %0d want 62", alloc_tag[5:0]); else n_pass++;
        tick();
        drv(2'b11, 2'b00, 0, 0); #1;
        n_chk++; if (alloc_gnt !== 1'b0 || stall !== 1'b1) $display("FAIL short_deny: gnt %0b stall %0b want 0 1", alloc_gnt, stall); else n_pass++;
        tick();
        n_chk++; if (free_count !== 7'd1) $display("FAIL short_count: got %0d want 1", free_count); else n_pass++;
        drv(2'b01, 2'b00, 0, 0); #1;
        n_chk++; if (alloc_gnt !== 1'b1 || alloc_tag[5:0] !== 6'd63) $display("FAIL short_63: gnt %0b tag %0d want 1 63", alloc_gnt, alloc_tag[5:0]); else n_pass++;
        tick();
    endtask

    task automatic test_checkpoint();
        test_reset();
        drv(2'b11, 2'b00, 0, 0); tick();
        drv(2'b11, 2'b00, 0, 0); tick();
        set_in(0, 2'b11, 2'b00, 0, 0, 1, 2, 0, 0); #1;
        n_chk++; if (alloc_tag !== {6'd21, 6'd20}) $display("FAIL ckpt_save_tags: got %0d,%0d want 20,21", alloc_tag[5:0], alloc_tag[11:6]); else n_pass++;
        tick();
        drv(2'b11, 2'b00, 0, 0); tick();
        drv(2'b11, 2'b00, 0, 0); tick();
        drv(2'b00, 2'b01, 20, 0); tick();
        set_in(0, 2'b11, 2'b00, 0, 0, 0, 0, 1, 2); #1;
        n_chk++; if (alloc_gnt !== 1'b0 || stall !== 1'b1) $display("FAIL ckpt_restore_nogrant: gnt %0b stall %0b want 0 1", alloc_gnt, stall); else n_pass++;
        tick();
        n_chk++; if (free_count !== 7'd43) $display("FAIL ckpt_restore_count: got %0d want 43", free_count); else n_pass++;
        drv(2'b01, 2'b00, 0, 0); #1;
        n_chk++; if (alloc_gnt !== 1'b1 || alloc_tag[5:0] !== 6'd20) $display("FAIL ckpt_first_grant: gnt %0b tag %0d want 1 20", alloc_gnt, alloc_tag[5:0]); else n_pass++;
        tick();
        drv(2'b10, 2'b00, 0, 0); #1;
        n_chk++; if (alloc_tag[11:6] !== 6'd22) $display("FAIL ckpt_skip21: got %0d want 22", alloc_tag[11:6]); else n_pass++;
        tick();
    endtask

    task automatic test_restore_save();
        set_in(0, 2'b00, 2'b00, 0, 0, 1, 1, 1, 2); tick();
        set_in(0, 2'b00, 2'b00, 0, 0, 0, 0, 1, 1); tick();
        n_chk++; if (free_count !== 7'd48) $display("FAIL rs_slot1_kept: got %0d want 48", free_count); else n_pass++;
        drv(2'b11, 2'b00, 0, 0); #1;
        n_chk++; if (alloc_tag !== {6'd17, 6'd16}) $display("FAIL rs_after: got %0d,%0d want 16,17", alloc_tag[5:0], alloc_tag[11:6]); else n_pass++;
        tick();
    endtask

    task automatic test_double_free();
        test_reset();
        drv(2'b00, 2'b01, 30, 0); tick();
        n_chk++; if (err_double_free !== 1'b1 || free_count !== 7'd48) $display("FAIL dbl_free_freed: err %0b count %0d want 1 48", err_double_free, free_count); else n_pass++;
        drv(2'b00, 2'b00, 0, 0); tick();
        n_chk++; if (err_double_free !== 1'b0) $display("FAIL dbl_pulse: got %0b want 0", err_double_free); else n_pass++;
        for (int c = 0; c < 8; c++) begin drv(2'b11, 2'b00, 0, 0); tick(); end
        drv(2'b00, 2'b11, 30, 30); tick();
        n_chk++; if (err_double_free !== 1'b1 || free_count !== 7'd33) $display("FAIL dbl_lanes: err %0b count %0d want 1 33", err_double_free, free_count); else n_pass++;
        drv(2'b00, 2'b00, 0, 0); tick();
        n_chk++; if (err_double_free !== 1'b0 || free_count !== 7'd33) $display("FAIL dbl_lanes_after: err %0b count %0d want 0 33", err_double_free, free_count); else n_pass++;
    endtask

    function automatic int pick_tag();
        int s;
        s = int'($urandom_range(63));
        if ($urandom_range(99) < 85)
            for (int i = 0; i < 64; i++)
                if (!m_fb[(s + i) % 64]) return (s + i) % 64;
        return s;
    endfunction

    task automatic test_random();
        int bad_c = 0;
        int bad_s = 0;
        int t0, t1;
        for (int c = 0; c < 400; c++) begin
            t0 = pick_tag(); t1 = pick_tag();
            set_in($urandom_range(99) == 0, 2'($urandom_range(3)), 2'($urandom_range(3)), t0, t1,
                   $urandom_range(7) == 0, int'($urandom_range(3)), $urandom_range(9) == 0,
                   int'($urandom_range(3)));
            #1;
            if (alloc_gnt !== e_gnt || stall !== e_stall || alloc_tag[5:0] !== 6'(e_tag[0]) ||
                alloc_tag[11:6] !== 6'(e_tag[1])) begin
                if (bad_c == 0) $display("FAIL rand_comb: cycle %0d gnt %0b stall %0b tags %0d,%0d want %0b %0b %0d,%0d", c, alloc_gnt, stall, alloc_tag[5:0], alloc_tag[11:6], e_gnt, e_stall, e_tag[0], e_tag[1]);
                bad_c++;
            end
            tick();
            if (free_count !== 7'(m_cnt) || err_double_free !== m_err) begin
                if (bad_s == 0) $display("FAIL rand_state: cycle %0d count %0d err %0b want %0d %0b", c, free_count, err_double_free, m_cnt, m_err);
                bad_s++;
            end
        end
        n_chk++; if (bad_c == 0) n_pass++;
        n_chk++; if (bad_s == 0) n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic_grant();
        test_exhaust();
        test_shortage();
        test_checkpoint();
        test_restore_save();
        test_double_free();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
